x25519_proj_to_affine: RTL and testbench



---
 rtl/x25519_pkg.sv | 13 +
 rtl/x25519_proj_to_affine_if.sv | 20 ++
 rtl/x25519_proj_to_affine_fmul.sv | 30 +++
 rtl/x25519_proj_to_affine.sv | 108 ++++++++++
 tb/tb_x25519_proj_to_affine.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/x25519_pkg.sv
// Shared X25519 constants and the inversion FSM state type.
package x25519_pkg;

  // p = 2^255 - 19
  localparam logic [255:0] P25519    = (256'd1 << 255) - 256'd19;
  // Fermat inversion exponent p - 2; bit i selects the multiply-by-Z step
  localparam logic [255:0] P_MINUS_2 = P25519 - 256'd2;
  // Montgomery ladder curve constant (A + 2) / 4
  localparam logic [16:0]  A24       = 17'd121666;

  typedef enum logic [2:0] {IDLE, SQR, MUL, FIN, DONE} inv_state_t;

endpackage

// File: rtl/x25519_proj_to_affine_if.sv
// Input (X:Z) and output (x) valid/ready channels of the converter.
interface x25519_proj_to_affine_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] X_in;
  logic [255:0] Z_in;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] x_out;

  modport master (
    output in_valid, X_in, Z_in, out_ready,
    input  in_ready, out_valid, x_out
  );

  modport slave (
    input  in_valid, X_in, Z_in, out_ready,
    output in_ready, out_valid, x_out
  );
endinterface

// File: rtl/x25519_proj_to_affine_fmul.sv
// GF(2^255-19) multiplier: result = a*b mod p, registered, one-cycle latency.
// Reduction folds the high part using 2^255 = 19 (mod p) twice, then one
// conditional subtract; valid for any 256-bit operands.
module Field_Multiplier
  import x25519_pkg::*;
(
  input  logic         clk,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic [255:0] result
);

  logic [511:0] prod;
  logic [262:0] fold1;
  logic [255:0] fold2;
  logic [255:0] red;

  // full product and two folding passes
  always_comb begin
    prod  = {256'b0, a} * {256'b0, b};
    fold1 = {8'b0, prod[254:0]} + ({6'b0, prod[511:255]} * 263'd19);
    fold2 = {1'b0, fold1[254:0]} + ({248'b0, fold1[262:255]} * 256'd19);
    red   = (fold2 >= P25519) ? (fold2 - P25519) : fold2;
  end

  // register the reduced product
  always_ff @(posedge clk)
    result <= red;

endmodule

// File: rtl/x25519_proj_to_affine.sv
// Projective (X:Z) to affine x = X * Z^(p-2) mod p via left-to-right
// square-and-multiply over a single shared field multiplier.
module x25519_proj_to_affine
  import x25519_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  x25519_proj_to_affine_if.slave  bus
);

  inv_state_t   state;
  logic [7:0]   i;
  logic         first;
  logic [255:0] x_reg, z_reg;
  logic [255:0] mul_a, mul_b, mul_r;
  logic         in_ready_q, out_valid_q;
  logic [255:0] x_out_q;
  logic [255:0] exp_bits;
  logic         e_bit;

  assign exp_bits      = P_MINUS_2;
  assign e_bit         = exp_bits[i];
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.x_out     = x_out_q;

  Field_Multiplier u_fmul (
    .clk    (clk),
    .a      (mul_a),
    .b      (mul_b),
    .result (mul_r)
  );

  // operand select: the accumulator lives in the multiplier's output register
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      SQR: begin
        mul_a = first ? z_reg : mul_r;
        mul_b = first ? z_reg : mul_r;
      end
      MUL: begin
        mul_a = mul_r;
        mul_b = z_reg;
      end
      FIN: begin
        mul_a = mul_r;
        mul_b = x_reg;
      end
      default: ;
    endcase
  end

  // control FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      i           <= '0;
      first       <= 1'b0;
      x_reg       <= '0;
      z_reg       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      x_out_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_reg      <= bus.X_in;
            z_reg      <= bus.Z_in;
            i          <= 8'd253;
            first      <= 1'b1;
            in_ready_q <= 1'b0;
            state      <= SQR;
          end
        end
        SQR: begin
          first <= 1'b0;
          if (e_bit)        state <= MUL;
          else if (i == '0) state <= FIN;
          else              i     <= i - 8'd1;
        end
        MUL: begin
          if (i == '0) state <= FIN;
          else begin
            i     <= i - 8'd1;
            state <= SQR;
          end
        end
        FIN: state <= DONE;
        DONE: begin
          // first DONE cycle captures the final product from the multiplier
          if (!out_valid_q) begin
            x_out_q     <= mul_r;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x25519_proj_to_affine.sv
// Vector-table bench with an expected-result queue for x25519_proj_to_affine.
module tb_x25519_proj_to_affine;
  import x25519_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  x25519_proj_to_affine_if bus();

  x25519_proj_to_affine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q[$];

  // mode: 0 normal, 1 backpressure, 2 mid-conversion in_valid pulse, 3 reset at cycle 200
  typedef struct {
    logic [255:0] x;
    logic [255:0] z;
    logic [255:0] expv;
    int           mode;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = {256'b0, a} * {256'b0, b};
    t = t % {256'b0, P25519};
    return t[255:0];
  endfunction

  // right-to-left exponentiation, independent of the DUT's bit order
  function automatic logic [255:0] ref_conv(input logic [255:0] x, input logic [255:0] z);
    logic [255:0] e, base, acc;
    e    = P_MINUS_2;
    base = z;
    acc  = 256'd1;
    for (int k = 0; k < 255; k++) begin
      if (e[k]) acc = mulmod(acc, base);
      base = mulmod(base, base);
    end
    return mulmod(x, acc);
  endfunction

  function automatic logic [255:0] rand_fe();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    r[255] = 1'b0;
    if (r >= P25519) r = r - P25519;
    return r;
  endfunction

  task automatic run(input vec_t v, input int idx);
    int n;
    int bad;
    logic [255:0] held, want;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("in_ready_idle[%0d]", idx), {255'b0, bus.in_ready}, 256'd1);
    bus.X_in      = v.x;
    bus.Z_in      = v.z;
    bus.in_valid  = 1'b1;
    bus.out_ready = (v.mode != 1);
    exp_q.push_back(v.expv);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.X_in     = '0;
    bus.Z_in     = '0;
    chk($sformatf("in_ready_busy[%0d]", idx), {255'b0, bus.in_ready}, 256'd0);
    n = 0;
    while (!bus.out_valid && n < 600) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (v.mode == 2 && n == 100) begin
        chk($sformatf("in_ready_mid[%0d]", idx), {255'b0, bus.in_ready}, 256'd0);
        bus.X_in     = 256'd123;
        bus.Z_in     = 256'd5;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n++;
        bus.in_valid = 1'b0;
        bus.X_in     = '0;
        bus.Z_in     = '0;
      end
      if (v.mode == 3 && n == 200) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk($sformatf("rst_out_valid[%0d]", idx), {255'b0, bus.out_valid}, 256'd0);
        chk($sformatf("rst_x_out[%0d]", idx), bus.x_out, 256'd0);
        chk($sformatf("rst_in_ready[%0d]", idx), {255'b0, bus.in_ready}, 256'd1);
        exp_q.delete();
        return;
      end
    end
    chk($sformatf("latency[%0d]", idx), 256'(n), 256'd508);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    chk($sformatf("x_out[%0d]", idx), bus.x_out, want);
    if (v.mode == 1) begin
      held = bus.x_out;
      bad  = 0;
      repeat (20) begin
        @(posedge clk);
        @(negedge clk);
        if (bus.x_out !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
      end
      chk($sformatf("backpressure_hold[%0d]", idx), 256'(bad), 256'd0);
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("in_ready_after_out[%0d]", idx), {255'b0, bus.in_ready}, 256'd1);
    chk($sformatf("out_valid_after_out[%0d]", idx), {255'b0, bus.out_valid}, 256'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] rx, rz;
    bus.in_valid  = 1'b0;
    bus.X_in      = '0;
    bus.Z_in      = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {255'b0, bus.in_ready}, 256'd1);
    chk("reset_out_valid", {255'b0, bus.out_valid}, 256'd0);
    chk("reset_x_out", bus.x_out, 256'd0);
    rst = 1'b0;

    vecs[0] = '{x: 256'd9,  z: 256'd1, expv: 256'd9, mode: 0};
    vecs[1] = '{x: 256'd1,  z: 256'd2, expv: (256'd1 << 254) - 256'd9, mode: 0};
    vecs[2] = '{x: 256'd7,  z: 256'd7, expv: 256'd1, mode: 1};
    vecs[3] = '{x: 256'd5,  z: 256'd0, expv: 256'd0, mode: 0};
    vecs[4] = '{x: 256'd11, z: 256'd13, expv: ref_conv(256'd11, 256'd13), mode: 2};
    rx = rand_fe();
    rz = rand_fe();
    vecs[5] = '{x: rx, z: rz, expv: ref_conv(rx, rz), mode: 3};
    vecs[6] = '{x: 256'd3, z: 256'd1, expv: 256'd3, mode: 0};
    for (int k = 7; k < 10; k++) begin
      rx = rand_fe();
      rz = rand_fe();
      vecs[k] = '{x: rx, z: rz, expv: ref_conv(rx, rz), mode: 0};
    end

    for (int k = 0; k < 10; k++) run(vecs[k], k);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
